// File: rtl/seven_segment_scan_pkg.sv
// seg7_pkg: shared seven-segment constants and active-low hex decode table
package seg7_pkg;
  localparam logic [6:0] SEG_OFF_AL = 7'h7F;
  localparam logic [6:0] HEX_SEG_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG_AL[nibble];
  endfunction
endpackage

// File: rtl/seven_segment_scan_if.sv
// seven_segment_scan_if: datapath-side inputs and display-pin outputs of the scan driver
interface seven_segment_scan_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    enable;
  logic                    blank_lz;
  logic [6:0]              segment;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit_sel;
  modport master (output value, dp_in, load, enable, blank_lz, input segment, dp, digit_sel);
  modport slave (input value, dp_in, load, enable, blank_lz, output segment, dp, digit_sel);
endinterface

// File: rtl/seven_segment_scan_hexdec.sv
// seven_segment_hexdec: combinational nibble to active-low gfedcba segment decoder
module seven_segment_hexdec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/seven_segment_scan.sv
// seven_segment_scan: time-multiplexed N-digit hex display driver with leading-zero blanking
module seven_segment_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic reset,
  seven_segment_scan_if.slave bus
);
  localparam int   IW  = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int   PW  = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam logic INV = !ACTIVE_LOW;
  logic [4*NUM_DIGITS-1:0] shadow_val, upper;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [6:0]              dec;
  logic                    blank, term;
  // upper holds the selected digit and everything left of it, so zero means a leading zero
  assign upper = shadow_val >> {idx, 2'b00};
  assign blank = bus.blank_lz && idx != '0 && upper == '0;
  assign term  = presc == PW'(REFRESH_DIV - 1);
  seven_segment_hexdec u_dec (.nibble(upper[3:0]), .seg(dec));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_val    <= '0;
      shadow_dp     <= '0;
      presc         <= '0;
      idx           <= '0;
      bus.segment   <= {7{INV}} ^ SEG_OFF_AL;
      bus.dp        <= !INV;
      bus.digit_sel <= {NUM_DIGITS{!INV}};
    end else begin
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_in;
      end
      if (bus.enable) begin
        presc <= term ? '0 : presc + 1'b1;
        if (term) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      end
      bus.segment   <= {7{INV}} ^ (bus.enable && !blank ? dec : SEG_OFF_AL);
      bus.dp        <= INV ^ !(bus.enable && shadow_dp[idx]);
      bus.digit_sel <= {NUM_DIGITS{INV}} ^ ~(bus.enable ? NUM_DIGITS'(1) << idx : '0);
    end
  end
endmodule

// File: tb/tb_seven_segment_scan.sv
// tb_seven_segment_scan: random and directed scan stimulus against a cycle-count reference model
module tb_seven_segment_scan;
  localparam int ND  = 4;
  localparam int DIV = 4;
  logic clk = 0, rst = 0;
  logic [15:0] val = 0;
  logic [3:0]  dpi = 0;
  logic ld = 0, en = 0, blz = 0, check_on = 0;
  int n_chk = 0, n_fail = 0;
  seven_segment_scan_if #(.NUM_DIGITS(ND)) b0 ();
  seven_segment_scan_if #(.NUM_DIGITS(ND)) b1 ();
  assign b0.value = val;  assign b1.value = val;
  assign b0.dp_in = dpi;  assign b1.dp_in = dpi;
  assign b0.load = ld;    assign b1.load = ld;
  assign b0.enable = en;  assign b1.enable = en;
  assign b0.blank_lz = blz; assign b1.blank_lz = blz;
  seven_segment_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .ACTIVE_LOW(1)) dut0 (.clk(clk), .reset(rst), .bus(b0));
  seven_segment_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .ACTIVE_LOW(0)) dut1 (.clk(clk), .reset(rst), .bus(b1));
  always #5 clk = ~clk;
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  // Model state: enabled-cycle count since reset fully determines the scan position
  int unsigned pos;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [6:0]  e_seg, x_seg;
  logic        e_dp, x_dp;
  logic [3:0]  e_sel, x_sel;
  assign x_seg = ~e_seg;
  assign x_dp  = ~e_dp;
  assign x_sel = ~e_sel;
  function automatic logic [11:0] model_out(int unsigned p, logic [15:0] v, logic [3:0] dv, logic e, logic b);
    int unsigned d, hi;
    d  = (p / DIV) % ND;
    hi = v / (16 ** d);
    if (!e) return {4'hF, 1'b1, 7'h7F};
    return {~(4'b0001 << d), ~dv[d], (b && d != 0 && hi == 0) ? 7'h7F : tbl[hi % 16]};
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= 0; m_val <= 0; m_dp <= 0;
      {e_sel, e_dp, e_seg} <= {4'hF, 1'b1, 7'h7F};
    end else begin
      {e_sel, e_dp, e_seg} <= model_out(pos, m_val, m_dp, en, blz);
      pos <= en ? pos + 1 : pos;
      if (ld) begin
        m_val <= val;
        m_dp  <= dpi;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (check_on) begin
    check("seg_al", 32'(b0.segment), 32'(e_seg));
    check("dp_al", 32'(b0.dp), 32'(e_dp));
    check("sel_al", 32'(b0.digit_sel), 32'(e_sel));
    check("seg_ah", 32'(b1.segment), 32'(x_seg));
    check("dp_ah", 32'(b1.dp), 32'(x_dp));
    check("sel_ah", 32'(b1.digit_sel), 32'(x_sel));
  end
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    val = v; dpi = d; ld = 1;
    @(negedge clk);
    ld = 0;
  endtask
  task automatic async_reset(input int dly);
    @(negedge clk);
    #(dly);
    rst = 1;
    #1;
    check("rst_seg", 32'(b0.segment), 32'h7F);
    check("rst_dp", 32'(b0.dp), 32'h1);
    check("rst_sel", 32'(b0.digit_sel), 32'hF);
    check("rst_seg_ah", 32'(b1.segment), 32'h00);
    check("rst_sel_ah", 32'(b1.digit_sel), 32'h0);
    cycles(2);
    rst = 0;
  endtask
  initial begin
    #1 rst = 1;
    #1;
    check("por_seg", 32'(b0.segment), 32'h7F);
    check("por_dp", 32'(b0.dp), 32'h1);
    check("por_sel", 32'(b0.digit_sel), 32'hF);
    check_on = 1;
    cycles(10);
    rst = 0;
    en = 1;
    load_val(16'h1A2F, 4'h0);
    cycles(20);
    blz = 1;
    load_val(16'h0005, 4'h0);
    cycles(20);
    load_val(16'h0000, 4'h0);
    cycles(20);
    blz = 0;
    cycles(20);
    val = 16'h8888;
    cycles(20);
    load_val(16'h8888, 4'b0100);
    cycles(20);
    cycles(9);
    en = 0;
    cycles(20);
    en = 1;
    cycles(20);
    async_reset(3);
    en = 1;
    load_val(16'h1A2F, 4'h0);
    cycles(20);
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] mask;
      case ($urandom_range(0, 4))
        0: mask = 16'h0000;
        1: mask = 16'h000F;
        2: mask = 16'h00FF;
        3: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      if ($urandom_range(0, 299) == 0) async_reset($urandom_range(1, 4));
      @(negedge clk);
      val = 16'($urandom) & mask;
      dpi = 4'($urandom);
      ld  = $urandom_range(0, 7) == 0;
      en  = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) blz = ~blz;
    end
    ld = 0;
    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
